gemv_result_packer: RTL



---
 rtl/gemv_result_packer_if.sv | 32 +++
 rtl/gemv_result_packer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/gemv_result_packer_if.sv
// Handshake bundle between the GEMV row-result producer, the packer and the write-back path.
// The master side sources config, row vectors and out_rdy; the slave side is the packer.
interface gemv_result_packer_if #(
    parameter int PARALLEL_ROW  = 32,
    parameter int FP_WIDTH      = 16,
    parameter int OUT_LANES     = 8,
    parameter int VEC_CNT_WIDTH = 8
);
    logic [VEC_CNT_WIDTH-1:0]         cfg_vec_num;
    logic                             cfg_vld;
    logic                             cfg_rdy;
    logic [PARALLEL_ROW*FP_WIDTH-1:0] fp_macro_result;
    logic                             fp_macro_result_vld;
    logic                             fp_macro_result_rdy;
    logic [OUT_LANES*FP_WIDTH-1:0]    out_data;
    logic                             out_vld;
    logic                             out_rdy;
    logic                             out_last_beat;
    logic                             out_last;
    logic                             busy;
    logic                             done;

    modport master (
        output cfg_vec_num, cfg_vld, fp_macro_result, fp_macro_result_vld, out_rdy,
        input  cfg_rdy, fp_macro_result_rdy, out_data, out_vld, out_last_beat, out_last, busy, done
    );

    modport slave (
        input  cfg_vec_num, cfg_vld, fp_macro_result, fp_macro_result_vld, out_rdy,
        output cfg_rdy, fp_macro_result_rdy, out_data, out_vld, out_last_beat, out_last, busy, done
    );
endinterface

// File: rtl/gemv_result_packer.sv
// Ping-pong buffer of two bf16 row vectors, drained as OUT_LANES-wide beats with
// vector/job boundary tags and a done pulse when the configured vector count has left.
module gemv_result_packer #(
    parameter int PARALLEL_ROW  = 32,
    parameter int FP_WIDTH      = 16,
    parameter int OUT_LANES     = 8,
    parameter int VEC_CNT_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    gemv_result_packer_if.slave bus
);
    localparam int BEATS  = PARALLEL_ROW / OUT_LANES;
    localparam int VEC_W  = PARALLEL_ROW * FP_WIDTH;
    localparam int BEAT_W = OUT_LANES * FP_WIDTH;
    localparam logic [VEC_CNT_WIDTH-1:0] LAST_BEAT = VEC_CNT_WIDTH'(BEATS - 1);
    localparam logic [VEC_CNT_WIDTH-1:0] CNT_ONE   = VEC_CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state_r;
    logic [VEC_CNT_WIDTH-1:0] vec_num_r;
    logic [VEC_CNT_WIDTH-1:0] in_vec_cnt_r;
    logic [VEC_CNT_WIDTH-1:0] out_vec_cnt_r;
    logic [VEC_CNT_WIDTH-1:0] beat_r;
    logic [1:0]               buf_count_r;
    logic                     wr_ptr_r;
    logic                     rd_ptr_r;
    logic                     done_r;
    logic [VEC_W-1:0]         slot_r [2];

    logic              push_s;
    logic              pop_s;
    logic              free_s;
    logic              last_vec_s;
    logic              out_vld_s;
    logic              in_rdy_s;
    logic              last_beat_s;
    logic [BEAT_W-1:0] beat_data_s;

    // Handshake qualifiers and the head-slot beat view; every term is a function of registers or inputs.
    always_comb begin
        out_vld_s   = (buf_count_r != 2'd0);
        in_rdy_s    = (state_r == RUN) && (buf_count_r < 2'd2) && (in_vec_cnt_r < vec_num_r);
        push_s      = bus.fp_macro_result_vld && in_rdy_s;
        pop_s       = out_vld_s && bus.out_rdy;
        last_beat_s = out_vld_s && (beat_r == LAST_BEAT);
        free_s      = pop_s && (beat_r == LAST_BEAT);
        last_vec_s  = (out_vec_cnt_r == (vec_num_r - CNT_ONE));
        if (out_vld_s) begin
            beat_data_s = slot_r[rd_ptr_r][int'(beat_r) * BEAT_W +: BEAT_W];
        end else begin
            beat_data_s = '0;
        end
    end

    assign bus.cfg_rdy             = (state_r == IDLE);
    assign bus.busy                = (state_r == RUN);
    assign bus.done                = done_r;
    assign bus.fp_macro_result_rdy = in_rdy_s;
    assign bus.out_vld             = out_vld_s;
    assign bus.out_data            = beat_data_s;
    assign bus.out_last_beat       = last_beat_s;
    assign bus.out_last            = last_beat_s && last_vec_s;

    // Job FSM, ping-pong storage, counters and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            vec_num_r     <= '0;
            in_vec_cnt_r  <= '0;
            out_vec_cnt_r <= '0;
            beat_r        <= '0;
            buf_count_r   <= 2'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            done_r        <= 1'b0;
            slot_r[0]     <= '0;
            slot_r[1]     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.cfg_vld) begin
                        if (bus.cfg_vec_num != '0) begin
                            state_r       <= RUN;
                            vec_num_r     <= bus.cfg_vec_num;
                            in_vec_cnt_r  <= '0;
                            out_vec_cnt_r <= '0;
                            beat_r        <= '0;
                            wr_ptr_r      <= 1'b0;
                            rd_ptr_r      <= 1'b0;
                        end else begin
                            // An empty job completes immediately without touching the buffer.
                            done_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push_s) begin
                        slot_r[wr_ptr_r] <= bus.fp_macro_result;
                        wr_ptr_r         <= ~wr_ptr_r;
                        in_vec_cnt_r     <= in_vec_cnt_r + CNT_ONE;
                    end
                    if (pop_s) begin
                        if (free_s) begin
                            beat_r        <= '0;
                            rd_ptr_r      <= ~rd_ptr_r;
                            out_vec_cnt_r <= out_vec_cnt_r + CNT_ONE;
                            if (last_vec_s) begin
                                state_r <= IDLE;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            beat_r <= beat_r + CNT_ONE;
                        end
                    end
                    // A push and a slot release in the same cycle cancel out.
                    buf_count_r <= buf_count_r + {1'b0, push_s} - {1'b0, free_s};
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
